// File: rtl/dmem_mmio_ctrl_if.sv
// dmem_mmio_ctrl_if: CPU MEM-stage data bus between the pipeline and the data memory/MMIO block
interface dmem_mmio_ctrl_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    modport master(output memwrite, memaddr, memwritedata, input memreaddata);
    modport slave(input memwrite, memaddr, memwritedata, output memreaddata);
endinterface

// File: rtl/dmem_mmio_ctrl.sv
// dmem_mmio_ctrl: word-addressed data RAM plus LED, switch and timer MMIO registers
module dmem_mmio_ctrl #(
    parameter int RAM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    dmem_mmio_ctrl_if.slave   bus,
    input  logic [15:0]       switches,
    output logic [15:0]       leds,
    output logic              timer_irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [2:0] SEL_LED = 3'd0, SEL_SW = 3'd1, SEL_TCNT = 3'd2, SEL_TCMP = 3'd3, SEL_TCTRL = 3'd4;

    logic [31:0]   ram [RAM_WORDS];
    logic [15:0]   sw_meta, sw_sync;
    logic [31:0]   tcount, tcmp;
    logic          en, autoreload, ie, match;
    logic          in_ram, in_mmio, wr_mmio, at_cmp, match_now, unused;
    logic [2:0]    sel;
    logic [AW-1:0] widx;

    assign in_ram    = bus.memaddr[31:AW+2] == '0;
    assign in_mmio   = bus.memaddr[31:16] == 16'hFFFF;
    assign sel       = bus.memaddr[4:2];
    assign widx      = bus.memaddr[AW+1:2];
    assign wr_mmio   = bus.memwrite && in_mmio;
    assign at_cmp    = tcount == tcmp;
    assign match_now = en && at_cmp;
    assign timer_irq = match & ie;
    assign unused    = ^bus.memaddr[1:0];

    // Combinational readback: the CPU samples this at the end of its MEM cycle
    always_comb begin
        bus.memreaddata = in_ram             ? ram[widx] :
                          !in_mmio           ? 32'h0 :
                          sel == SEL_LED     ? {16'h0, leds} :
                          sel == SEL_SW      ? {16'h0, sw_sync} :
                          sel == SEL_TCNT    ? tcount :
                          sel == SEL_TCMP    ? tcmp :
                          sel == SEL_TCTRL   ? {23'h0, match, 5'h0, ie, autoreload, en} :
                                               32'h0;
    end

    always_ff @(posedge clk) begin
        if (bus.memwrite && in_ram) ram[widx] <= bus.memwritedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds       <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            tcount     <= '0;
            tcmp       <= 32'hFFFF_FFFF;
            en         <= 1'b0;
            autoreload <= 1'b0;
            ie         <= 1'b0;
            match      <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (wr_mmio && sel == SEL_LED) leds <= bus.memwritedata[15:0];
            if (wr_mmio && sel == SEL_TCMP) tcmp <= bus.memwritedata;
            if (wr_mmio && sel == SEL_TCTRL) {ie, autoreload, en} <= bus.memwritedata[2:0];
            // A match set in the same cycle as a W1C clear wins
            match  <= match_now || (match && !(wr_mmio && sel == SEL_TCTRL && bus.memwritedata[8]));
            tcount <= (wr_mmio && sel == SEL_TCNT) ? bus.memwritedata :
                      !en                          ? tcount :
                      (autoreload && at_cmp)       ? 32'h0 :
                                                     tcount + 32'd1;
        end
    end
endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// tb_dmem_mmio_ctrl: table-driven and sequence checks of RAM, MMIO and timer behaviour
module tb_dmem_mmio_ctrl;
    localparam logic [31:0] A_LED = 32'hFFFF_0000, A_SW = 32'hFFFF_0004, A_TCNT = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP = 32'hFFFF_000C, A_TCTRL = 32'hFFFF_0010, A_BAD = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] switches = '0;
    logic [15:0] leds;
    logic        timer_irq;
    int          nvec = 0;
    int          nmiss = 0;

    dmem_mmio_ctrl_if bus();

    dmem_mmio_ctrl #(.RAM_WORDS(2048)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .switches(switches),
        .leds(leds),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        bit          care;
        string       name;
    } sb_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          care;
        string       name;
    } vec_t;

    sb_t  sbq[$];
    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one bus cycle just after a rising edge, check the read mid-cycle, return after the next edge
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input bit care, input string name);
        sb_t e;
        bus.memwrite     = we;
        bus.memaddr      = a;
        bus.memwritedata = wd;
        e.exp = exp;
        e.care = care;
        e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        if (e.care) chk(e.name, bus.memreaddata, e.exp);
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp, input string name);
        step(1'b1, a, wd, exp, 1'b1, name);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        step(1'b0, a, 32'h0, exp, 1'b1, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt = '{
            '{1'b1, 32'h40,         32'h1111_1111, 32'h0,         1'b0, "ram_init"},
            '{1'b1, 32'h40,         32'hDEAD_BEEF, 32'h1111_1111, 1'b1, "ram_same_cycle_old"},
            '{1'b0, 32'h40,         32'h0,         32'hDEAD_BEEF, 1'b1, "ram_next_cycle"},
            '{1'b0, 32'h43,         32'h0,         32'hDEAD_BEEF, 1'b1, "ram_byte_bits_ignored"},
            '{1'b1, 32'h1FFC,       32'hCAFE_F00D, 32'h0,         1'b0, "ram_top_init"},
            '{1'b0, 32'h1FFC,       32'h0,         32'hCAFE_F00D, 1'b1, "ram_top_word"},
            '{1'b1, 32'h2040,       32'h5555_5555, 32'h0,         1'b1, "past_ram_write"},
            '{1'b0, 32'h2040,       32'h0,         32'h0,         1'b1, "past_ram_read"},
            '{1'b0, 32'h40,         32'h0,         32'hDEAD_BEEF, 1'b1, "ram_no_alias"},
            '{1'b1, 32'h8000_0000,  32'h1234_5678, 32'h0,         1'b1, "unmapped_write"},
            '{1'b0, 32'h8000_0000,  32'h0,         32'h0,         1'b1, "unmapped_read"},
            '{1'b1, A_LED,          32'h0001_A5A5, 32'h0,         1'b1, "led_write"},
            '{1'b0, A_LED,          32'h0,         32'h0000_A5A5, 1'b1, "led_read"},
            '{1'b0, A_SW,           32'h0,         32'h0,         1'b1, "sw_reset"},
            '{1'b0, A_TCNT,         32'h0,         32'h0,         1'b1, "tcount_reset"},
            '{1'b0, A_TCMP,         32'h0,         32'hFFFF_FFFF, 1'b1, "tcmp_reset"},
            '{1'b0, A_TCTRL,        32'h0,         32'h0,         1'b1, "tctrl_reset"},
            '{1'b1, A_TCTRL,        32'hFFFF_FEF8, 32'h0,         1'b1, "tctrl_other_bits_w"},
            '{1'b0, A_TCTRL,        32'h0,         32'h0,         1'b1, "tctrl_other_bits_r"},
            '{1'b1, A_BAD,          32'hFFFF_FFFF, 32'h0,         1'b1, "unmapped_reg_w"},
            '{1'b0, A_BAD,          32'h0,         32'h0,         1'b1, "unmapped_reg_r"},
            '{1'b0, A_TCNT,         32'h0,         32'h0,         1'b1, "tcount_held"}
        };
        bus.memwrite = 1'b0;
        bus.memaddr = A_TCMP;
        bus.memwritedata = 32'h0;
        #2 reset = 1'b1;
        #2;
        chk("reset_leds", {16'h0, leds}, 32'h0);
        chk("reset_irq", {31'h0, timer_irq}, 32'h0);
        chk("reset_tcmp_read", bus.memreaddata, 32'hFFFF_FFFF);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vt[i]) step(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].care, vt[i].name);
        chk("leds_pins", {16'h0, leds}, 32'h0000_A5A5);

        wr(A_TCMP, 32'd5, 32'hFFFF_FFFF, "oneshot_tcmp_w");
        wr(A_TCNT, 32'd0, 32'd0, "oneshot_tcnt_w");
        wr(A_TCTRL, 32'h5, 32'h0, "oneshot_tctrl_w");
        for (int i = 0; i < 8; i++) begin
            rd(A_TCNT, i, "oneshot_count");
            chk("oneshot_irq", {31'h0, timer_irq}, (i >= 5) ? 32'd1 : 32'd0);
        end
        wr(A_TCTRL, 32'h100, 32'h105, "oneshot_stop");
        chk("irq_cleared", {31'h0, timer_irq}, 32'd0);
        rd(A_TCNT, 32'd9, "stopped_a");
        rd(A_TCNT, 32'd9, "stopped_b");

        wr(A_TCMP, 32'd3, 32'd5, "reload_tcmp_w");
        wr(A_TCNT, 32'd0, 32'd9, "reload_tcnt_w");
        wr(A_TCTRL, 32'h7, 32'h0, "reload_tctrl_w");
        for (int i = 0; i < 8; i++) rd(A_TCNT, i % 4, "reload_count");
        rd(A_TCNT, 32'd0, "reload_r0");
        wr(A_TCTRL, 32'h107, 32'h107, "w1c_clear");
        chk("irq_after_w1c", {31'h0, timer_irq}, 32'd0);
        rd(A_TCTRL, 32'h007, "match_cleared");
        wr(A_TCTRL, 32'h107, 32'h007, "w1c_vs_set");
        rd(A_TCTRL, 32'h107, "match_kept");
        chk("irq_match_kept", {31'h0, timer_irq}, 32'd1);
        rd(A_TCNT, 32'd1, "reload_continues");

        wr(A_TCTRL, 32'h101, 32'h107, "wrap_tctrl_w");
        wr(A_TCNT, 32'hFFFF_FFFF, 32'd3, "wrap_tcnt_w");
        rd(A_TCNT, 32'hFFFF_FFFF, "wrap_pre");
        rd(A_TCNT, 32'd0, "wrap_post");
        wr(A_TCNT, 32'd100, 32'd1, "prec_write");
        rd(A_TCNT, 32'd100, "prec_result");

        wr(A_TCMP, 32'd49, 32'd3, "rst_tcmp_w");
        wr(A_TCTRL, 32'h104, 32'h101, "rst_tctrl_w");
        wr(A_TCNT, 32'd49, 32'd103, "rst_tcnt_w");
        wr(A_TCTRL, 32'h105, 32'h004, "rst_tctrl_en");
        rd(A_TCNT, 32'd49, "rst_pre_match");
        bus.memaddr = A_TCNT;
        #1;
        chk("count_50", bus.memreaddata, 32'd50);
        chk("irq_before_reset", {31'h0, timer_irq}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_count", bus.memreaddata, 32'd0);
        chk("async_irq", {31'h0, timer_irq}, 32'd0);
        chk("async_leds", {16'h0, leds}, 32'd0);
        bus.memaddr = A_TCMP;
        #1;
        chk("async_tcmp", bus.memreaddata, 32'hFFFF_FFFF);
        reset = 1'b0;
        rd(A_TCNT, 32'd0, "stopped_after_reset_a");
        rd(A_TCNT, 32'd0, "stopped_after_reset_b");
        rd(A_TCTRL, 32'd0, "tctrl_after_reset");

        switches = 16'h1234;
        rd(A_SW, 32'h0, "sw_lag1");
        rd(A_SW, 32'h0, "sw_lag2");
        rd(A_SW, 32'h1234, "sw_visible");

        if (sbq.size() != 0) begin
            nmiss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_ctrl.md
DMEM_MMIO_CTRL -- requirements
Module: dmem_mmio_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 2048, giving the data RAM depth in 32-bit words (a power of two).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memwrite  input  1  store strobe from the CPU MEM stage.
REQ-006 memaddr  input  32  byte address from the CPU MEM stage.
REQ-007 memwritedata  input  32  store data.
REQ-008 memreaddata  output  32  load data returned to the CPU in the same cycle.
REQ-009 switches  input  16  board switch levels.
REQ-010 leds  output  16  board LED drive.
REQ-011 timer_irq  output  1  timer interrupt request, level.

Function
REQ-012 Address bits [1:0] SHALL be ignored; all accesses are whole words.
REQ-013 The RAM region SHALL be memaddr < RAM_WORDS*4; word index = memaddr[log2(RAM_WORDS)+1:2].
REQ-014 The MMIO region SHALL be memaddr[31:16] = 16'hFFFF, with registers decoded on memaddr[4:2]:
  - 0xFFFF0000 LED (R/W, bits 15:0)
  - 0xFFFF0004 SW (RO)
  - 0xFFFF0008 TCOUNT (R/W)
  - 0xFFFF000C TCMP (R/W)
  - 0xFFFF0010 TCTRL (bit0 EN, bit1 AUTORELOAD, bit2 IE, bit8 MATCH).
REQ-015 Reads SHALL be combinational from memaddr, with no latency, because the CPU latches memreaddata at the end of its MEM cycle.
REQ-016 RAM writes SHALL occur on the rising edge when memwrite=1 and the address is in the RAM region; a read of the same address in that cycle SHALL return the old word.
REQ-017 Reads of unmapped addresses SHALL return 32'h0, and writes to unmapped addresses SHALL have no effect.
REQ-018 Reads of LED and SW SHALL return {16'h0, value}, and writes to LED SHALL store memwritedata[15:0].
REQ-019 SW SHALL be registered through two flops before readback, so a switch change is visible two cycles later.
REQ-020 TCTRL writes SHALL update EN, AUTORELOAD and IE; writing 1 to bit8 SHALL clear MATCH; other bits SHALL read as 0.
REQ-021 When EN=1, TCOUNT SHALL increment by 1 per cycle, modulo 2^32 (0xFFFFFFFF wraps to 0). When EN=0, TCOUNT SHALL hold.
REQ-022 When EN=1 and TCOUNT==TCMP, MATCH SHALL be set at that edge. If AUTORELOAD=1, TCOUNT SHALL load 0 at that edge instead of incrementing.
REQ-023 A CPU write to TCOUNT SHALL take precedence over increment and reload in the same cycle.
REQ-024 If a MATCH set and a W1C write to MATCH occur in the same cycle, the set SHALL win.
REQ-025 timer_irq SHALL equal MATCH & IE, driven from registers with no combinational input path.
REQ-026 Only one register is addressed per cycle, so there SHALL be no simultaneous-write conflict between CPU registers.

Reset
REQ-027 On reset assertion, asynchronously: leds=0, TCOUNT=0, TCMP=32'hFFFFFFFF, EN=AUTORELOAD=IE=MATCH=0, SW sync flops=0, timer_irq=0.
REQ-028 RAM contents SHALL NOT be reset.
REQ-029 Reset asserted mid-count SHALL stop the timer immediately, and it SHALL stay stopped after release until EN is written.
REQ-030 Reads during reset SHALL still follow REQ-015 using the reset register values.

Verification
REQ-031 RAM: write 0xDEADBEEF to 0x40; same-cycle read of 0x40 returns the prior value; next-cycle read of 0x40 returns 0xDEADBEEF; read of 0x43 also returns 0xDEADBEEF.
REQ-032 Unmapped and LED: write 0x12345678 to 0x8000_0000, then read it -> 0. Write 0x0001A5A5 to 0xFFFF0000 -> leds=0xA5A5 and readback 0x0000A5A5.
REQ-033 Timer one-shot: TCMP=5, TCOUNT=0, TCTRL=0x5 -> MATCH set at the edge where count==5, timer_irq=1 one cycle later, count continues to 6, 7 and onward.
REQ-034 Timer autoreload: TCMP=3, TCTRL=0x7 -> count sequence 0,1,2,3,0,1...; a W1C to MATCH coinciding with a match edge leaves MATCH=1.
REQ-035 Wrap and precedence: TCOUNT=0xFFFFFFFF with EN=1 -> 0 next cycle; a TCOUNT write of 100 on an enabled cycle -> 100, not an incremented value.
REQ-036 Asynchronous reset mid-count (count=50, irq=1) -> count=0, irq=0, leds=0 without waiting for a clock edge; SW readback reflects a switch change two cycles after the change.
